// File: rtl/dcache_pkg.sv
// Shared state type, default geometry and byte-merge helper for the data-cache responder.
package dcache_pkg;

   localparam int unsigned DefLines     = 64;
   localparam int unsigned DefLineWords = 4;
   localparam int unsigned DefOffsetW   = $clog2(DefLineWords);
   localparam int unsigned DefIndexW    = $clog2(DefLines);
   localparam int unsigned DefTagW      = 30 - DefIndexW - DefOffsetW;

   typedef enum logic [1:0] {StIdle, StRefill, StWrite, StDone} dcache_state_e;

   function automatic logic [31:0] merge_bytes(input logic [31:0] word,
                                                input logic [31:0] data,
                                                input logic [3:0]  strb);
      logic [31:0] res;
      res = word;
      for (int b = 0; b < 4; b++) begin
         if (strb[b]) res[8*b +: 8] = data[8*b +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/dcache_line_store.sv
// Valid/tag/data arrays for the direct-mapped cache; lookup is purely combinational.
module dcache_line_store
   import dcache_pkg::*;
#(
   parameter int unsigned LINES      = DefLines,
   parameter int unsigned LINE_WORDS = DefLineWords,
   parameter int unsigned OffW       = DefOffsetW,
   parameter int unsigned IdxW       = DefIndexW,
   parameter int unsigned TagW       = DefTagW
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic [IdxW-1:0] lookup_idx_i,
   input  logic [TagW-1:0] lookup_tag_i,
   input  logic [OffW-1:0] lookup_off_i,
   output logic            hit_o,
   output logic [31:0]     word_o,
   input  logic            refill_we_i,
   input  logic [IdxW-1:0] refill_idx_i,
   input  logic [OffW-1:0] refill_off_i,
   input  logic [31:0]     refill_data_i,
   input  logic            commit_we_i,
   input  logic [IdxW-1:0] commit_idx_i,
   input  logic [TagW-1:0] commit_tag_i,
   input  logic            merge_we_i,
   input  logic [IdxW-1:0] merge_idx_i,
   input  logic [OffW-1:0] merge_off_i,
   input  logic [31:0]     merge_data_i,
   input  logic [3:0]      merge_strb_i
);

   logic [LINES-1:0] valid_q;
   logic [TagW-1:0]  tag_q  [LINES];
   logic [31:0]      data_q [LINES][LINE_WORDS];

   assign hit_o  = valid_q[lookup_idx_i] && (tag_q[lookup_idx_i] == lookup_tag_i);
   assign word_o = data_q[lookup_idx_i][lookup_off_i];

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         valid_q <= '0;
      end else if (commit_we_i) begin
         valid_q[commit_idx_i] <= 1'b1;
      end
   end

   // Tags and data are deliberately left unreset; valid bits alone gate hits.
   always_ff @(posedge clk_i) begin
      if (commit_we_i) tag_q[commit_idx_i] <= commit_tag_i;
      if (refill_we_i) begin
         data_q[refill_idx_i][refill_off_i] <= refill_data_i;
      end else if (merge_we_i) begin
         data_q[merge_idx_i][merge_off_i] <=
            merge_bytes(data_q[merge_idx_i][merge_off_i], merge_data_i, merge_strb_i);
      end
   end

endmodule

// File: rtl/data_cache_responder.sv
// Direct-mapped, write-through, no-write-allocate data cache on a single-beat backing port.
// Define DCACHE_PERF_CNT_EN to add hit_count_o/miss_count_o counters.
module data_cache_responder
   import dcache_pkg::*;
#(
   parameter int unsigned LINES      = DefLines,
   parameter int unsigned LINE_WORDS = DefLineWords
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        cpu_enabled_i,
   input  logic [29:0] cpu_address_i,
   input  logic [3:0]  cpu_write_en_i,
   input  logic [31:0] cpu_data_i,
   output logic [31:0] cpu_data_o,
   output logic        cpu_blocking_n_o,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [29:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   output logic [3:0]  mem_wstrb_o,
   input  logic        mem_ack_i,
   input  logic [31:0] mem_rdata_i
`ifdef DCACHE_PERF_CNT_EN
   ,
   output logic [31:0] hit_count_o,
   output logic [31:0] miss_count_o
`endif
);

   localparam int unsigned OffW = $clog2(LINE_WORDS);
   localparam int unsigned IdxW = $clog2(LINES);
   localparam int unsigned TagW = 30 - IdxW - OffW;
   localparam logic [OffW-1:0] LastBeat = OffW'(LINE_WORDS - 1);

   dcache_state_e   state_q, state_d;
   logic [OffW-1:0] beat_q, beat_d;
   logic [OffW-1:0] req_off;
   logic [IdxW-1:0] req_idx;
   logic [TagW-1:0] req_tag;
   logic            hit, is_store;
   logic            refill_we, commit_we, merge_we;
   logic [31:0]     hit_word;

   assign req_off  = cpu_address_i[OffW-1:0];
   assign req_idx  = cpu_address_i[OffW +: IdxW];
   assign req_tag  = cpu_address_i[29 -: TagW];
   assign is_store = |cpu_write_en_i;

   dcache_line_store #(
      .LINES      (LINES),
      .LINE_WORDS (LINE_WORDS),
      .OffW       (OffW),
      .IdxW       (IdxW),
      .TagW       (TagW)
   ) u_line_store (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .lookup_idx_i  (req_idx),
      .lookup_tag_i  (req_tag),
      .lookup_off_i  (req_off),
      .hit_o         (hit),
      .word_o        (hit_word),
      .refill_we_i   (refill_we),
      .refill_idx_i  (req_idx),
      .refill_off_i  (beat_q),
      .refill_data_i (mem_rdata_i),
      .commit_we_i   (commit_we),
      .commit_idx_i  (req_idx),
      .commit_tag_i  (req_tag),
      .merge_we_i    (merge_we),
      .merge_idx_i   (req_idx),
      .merge_off_i   (req_off),
      .merge_data_i  (cpu_data_i),
      .merge_strb_i  (cpu_write_en_i)
   );

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_q <= StIdle;
         beat_q  <= '0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
      end
   end

   always_comb begin
      state_d          = state_q;
      beat_d           = beat_q;
      cpu_blocking_n_o = 1'b1;
      mem_req_o        = 1'b0;
      mem_we_o         = 1'b0;
      mem_addr_o       = '0;
      mem_wdata_o      = '0;
      mem_wstrb_o      = '0;
      refill_we        = 1'b0;
      commit_we        = 1'b0;
      merge_we         = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (cpu_enabled_i) begin
               if (is_store) begin
                  cpu_blocking_n_o = 1'b0;
                  state_d          = StWrite;
               end else if (!hit) begin
                  cpu_blocking_n_o = 1'b0;
                  state_d          = StRefill;
                  beat_d           = '0;
               end
            end
         end
         StRefill: begin
            cpu_blocking_n_o = 1'b0;
            mem_req_o        = 1'b1;
            mem_addr_o       = {req_tag, req_idx, beat_q};
            if (mem_ack_i) begin
               refill_we = 1'b1;
               beat_d    = beat_q + 1'b1;
               if (beat_q == LastBeat) begin
                  commit_we = 1'b1;
                  state_d   = StIdle;
               end
            end
         end
         StWrite: begin
            cpu_blocking_n_o = 1'b0;
            mem_req_o        = 1'b1;
            mem_we_o         = 1'b1;
            mem_addr_o       = cpu_address_i;
            mem_wdata_o      = cpu_data_i;
            mem_wstrb_o      = cpu_write_en_i;
            if (mem_ack_i) begin
               merge_we = hit;
               state_d  = StDone;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
      endcase
      // Outputs are forced quiet for the whole time reset is held, even mid-transfer.
      if (!rst_i) begin
         cpu_blocking_n_o = 1'b1;
         mem_req_o        = 1'b0;
         mem_we_o         = 1'b0;
         mem_addr_o       = '0;
         mem_wdata_o      = '0;
         mem_wstrb_o      = '0;
         refill_we        = 1'b0;
         commit_we        = 1'b0;
         merge_we         = 1'b0;
      end
   end

   assign cpu_data_o = (rst_i && cpu_enabled_i && hit) ? hit_word : '0;

`ifdef DCACHE_PERF_CNT_EN
   logic [31:0] hit_cnt_q, miss_cnt_q;
   logic        refilled_q;

   // refilled_q suppresses the hit that a just-refilled load produces on its retry.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
         refilled_q <= 1'b0;
      end else if (state_q == StIdle && cpu_enabled_i) begin
         if (is_store) begin
            if (hit) hit_cnt_q <= hit_cnt_q + 1'b1;
            else     miss_cnt_q <= miss_cnt_q + 1'b1;
         end else if (!hit) begin
            miss_cnt_q <= miss_cnt_q + 1'b1;
         end else if (refilled_q) begin
            refilled_q <= 1'b0;
         end else begin
            hit_cnt_q <= hit_cnt_q + 1'b1;
         end
      end else if (commit_we) begin
         refilled_q <= 1'b1;
      end
   end

   assign hit_count_o  = hit_cnt_q;
   assign miss_count_o = miss_cnt_q;
`endif

endmodule

// File: tb/tb_data_cache_responder.sv
// Directed bench for data_cache_responder with a behavioural single-beat backing memory.
module tb_data_cache_responder;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        cpu_enabled_i;
   logic [29:0] cpu_address_i;
   logic [3:0]  cpu_write_en_i;
   logic [31:0] cpu_data_i;
   logic [31:0] cpu_data_o;
   logic        cpu_blocking_n_o;
   logic        mem_req_o;
   logic        mem_we_o;
   logic [29:0] mem_addr_o;
   logic [31:0] mem_wdata_o;
   logic [3:0]  mem_wstrb_o;
   logic        mem_ack_i;
   logic [31:0] mem_rdata_i;
`ifdef DCACHE_PERF_CNT_EN
   logic [31:0] hit_count_o;
   logic [31:0] miss_count_o;
`endif

   int checks = 0;
   int failures = 0;

   always #5 clk_i = ~clk_i;

   data_cache_responder dut (
      .clk_i            (clk_i),
      .rst_i            (rst_i),
      .cpu_enabled_i    (cpu_enabled_i),
      .cpu_address_i    (cpu_address_i),
      .cpu_write_en_i   (cpu_write_en_i),
      .cpu_data_i       (cpu_data_i),
      .cpu_data_o       (cpu_data_o),
      .cpu_blocking_n_o (cpu_blocking_n_o),
      .mem_req_o        (mem_req_o),
      .mem_we_o         (mem_we_o),
      .mem_addr_o       (mem_addr_o),
      .mem_wdata_o      (mem_wdata_o),
      .mem_wstrb_o      (mem_wstrb_o),
      .mem_ack_i        (mem_ack_i),
      .mem_rdata_i      (mem_rdata_i)
`ifdef DCACHE_PERF_CNT_EN
      ,
      .hit_count_o      (hit_count_o),
      .miss_count_o     (miss_count_o)
`endif
   );

   // Backing memory: fixed init pattern plus a write overlay cleared on reset.
   int unsigned ack_delay;
   int unsigned wait_cnt;
   int unsigned rd_count = 0;
   int unsigned wr_count = 0;
   logic [29:0] rd_log [256];
   logic [29:0] wr_addr_last;
   logic [3:0]  wr_strb_last;
   logic [31:0] wmem [1024];
   logic [1023:0] wvalid;
   logic [31:0] mem_cur;

   function automatic logic [31:0] init_word(input logic [9:0] a);
      case (a)
         10'h010: return 32'h0000_0011;
         10'h011: return 32'h0000_0022;
         10'h012: return 32'h0000_0033;
         10'h013: return 32'h0000_0044;
         default: return 32'h5000_0000 | {22'h0, a};
      endcase
   endfunction

   function automatic logic [31:0] tb_merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                            input logic [3:0] s);
      logic [31:0] mask;
      mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
      return (old_w & ~mask) | (new_w & mask);
   endfunction

   assign mem_cur     = wvalid[mem_addr_o[9:0]] ? wmem[mem_addr_o[9:0]] : init_word(mem_addr_o[9:0]);
   assign mem_rdata_i = mem_cur;
   assign mem_ack_i   = mem_req_o && (wait_cnt >= ack_delay);

   always @(posedge clk_i) begin
      if (!rst_i) begin
         wvalid   <= '0;
         wait_cnt <= 0;
      end else begin
         if (!mem_req_o || mem_ack_i) wait_cnt <= 0;
         else                         wait_cnt <= wait_cnt + 1;
         if (mem_req_o && mem_ack_i) begin
            if (mem_we_o) begin
               wmem[mem_addr_o[9:0]]   <= tb_merge(mem_cur, mem_wdata_o, mem_wstrb_o);
               wvalid[mem_addr_o[9:0]] <= 1'b1;
               wr_count     <= wr_count + 1;
               wr_addr_last <= mem_addr_o;
               wr_strb_last <= mem_wstrb_o;
            end else begin
               rd_log[rd_count[7:0]] <= mem_addr_o;
               rd_count <= rd_count + 1;
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic cyc;
      @(posedge clk_i);
      #1;
   endtask

   // Issues one request, holds it until blocking goes high, then lets it be consumed.
   task automatic run_req(input logic [31:0] byte_addr, input logic [3:0] strb,
                          input logic [31:0] wdata, output int stall,
                          output logic [31:0] rdata, output int unstable);
      logic [66:0] prev_pl;
      logic        prev_wait;
      cpu_enabled_i  = 1'b1;
      cpu_address_i  = byte_addr[31:2];
      cpu_write_en_i = strb;
      cpu_data_i     = wdata;
      #1;
      stall     = 0;
      unstable  = 0;
      prev_wait = 1'b0;
      prev_pl   = '0;
      while (!cpu_blocking_n_o && stall < 200) begin
         if (prev_wait && mem_req_o &&
             {mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o} !== prev_pl) unstable++;
         if (prev_wait && !mem_req_o) unstable++;
         prev_wait = mem_req_o && !mem_ack_i;
         prev_pl   = {mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o};
         cyc();
         stall++;
      end
      rdata = cpu_data_o;
      cyc();
      cpu_enabled_i  = 1'b0;
      cpu_write_en_i = 4'h0;
      #1;
   endtask

   task automatic test_reset;
      rst_i          = 1'b0;
      cpu_enabled_i  = 1'b1;
      cpu_address_i  = 30'h0000_0011;
      cpu_write_en_i = 4'hF;
      cpu_data_i     = 32'hFFFF_FFFF;
      for (int i = 0; i < 2; i++) begin
         cyc();
         checks++;
         if ({cpu_blocking_n_o, mem_req_o, mem_we_o} !== 3'b100) begin
            failures++;
            $display("FAIL reset_ctrl: got blk/req/we=%b required 100",
                     {cpu_blocking_n_o, mem_req_o, mem_we_o});
         end
         checks++;
         if ({mem_addr_o, mem_wdata_o, mem_wstrb_o, cpu_data_o} !== '0) begin
            failures++;
            $display("FAIL reset_data: got addr=%h wdata=%h wstrb=%h rdata=%h required all 0",
                     mem_addr_o, mem_wdata_o, mem_wstrb_o, cpu_data_o);
         end
      end
      cpu_enabled_i  = 1'b0;
      cpu_write_en_i = 4'h0;
      rst_i          = 1'b1;
      cyc();
      checks++;
      if ({cpu_blocking_n_o, mem_req_o} !== 2'b10) begin
         failures++;
         $display("FAIL post_reset_idle: got blk/req=%b required 10", {cpu_blocking_n_o, mem_req_o});
      end
`ifdef DCACHE_PERF_CNT_EN
      checks++;
      if ({hit_count_o, miss_count_o} !== 64'h0) begin
         failures++;
         $display("FAIL reset_counters: got hit=%0d miss=%0d required 0 0", hit_count_o, miss_count_o);
      end
`endif
   endtask

   task automatic test_cold_load;
      int          stall, unst;
      logic [31:0] rd;
      int unsigned rd0;
      rd0 = rd_count;
      run_req(32'h0000_0040, 4'h0, 32'h0, stall, rd, unst);
      checks++;
      if (stall !== 5) begin
         failures++;
         $display("FAIL cold_load_stall: got %0d required 5", stall);
      end
      checks++;
      if (rd !== 32'h0000_0011) begin
         failures++;
         $display("FAIL cold_load_data: got %h required 00000011", rd);
      end
      checks++;
      if ({rd_count - rd0, rd_log[rd0[7:0]], rd_log[rd0[7:0] + 8'd3]} !== {32'd4, 30'h10, 30'h13}) begin
         failures++;
         $display("FAIL cold_load_beats: got n=%0d first=%h last=%h required 4 10 13",
                  rd_count - rd0, rd_log[rd0[7:0]], rd_log[rd0[7:0] + 8'd3]);
      end
      run_req(32'h0000_0048, 4'h0, 32'h0, stall, rd, unst);
      checks++;
      if ({stall, rd} !== {32'd0, 32'h0000_0033}) begin
         failures++;
         $display("FAIL line_hit: got stall=%0d data=%h required 0 00000033", stall, rd);
      end
   endtask

   task automatic test_conflict;
      int          stall, unst;
      logic [31:0] rd;
      int unsigned rd0;
      rd0 = rd_count;
      run_req(32'h0000_0440, 4'h0, 32'h0, stall, rd, unst);
      checks++;
      if ({stall, rd, rd_log[rd0[7:0]]} !== {32'd5, 32'h5000_0110, 30'h110}) begin
         failures++;
         $display("FAIL conflict_fill: got stall=%0d data=%h first=%h required 5 50000110 110",
                  stall, rd, rd_log[rd0[7:0]]);
      end
      run_req(32'h0000_0040, 4'h0, 32'h0, stall, rd, unst);
      checks++;
      if ({stall, rd, rd_count - rd0} !== {32'd5, 32'h0000_0011, 32'd8}) begin
         failures++;
         $display("FAIL conflict_evict: got stall=%0d data=%h reads=%0d required 5 00000011 8",
                  stall, rd, rd_count - rd0);
      end
   endtask

   task automatic test_back_to_back_store_hit;
      int          stall, unst;
      logic [31:0] rd;
      int unsigned wr0, rd0;
      wr0 = wr_count;
      rd0 = rd_count;
      run_req(32'h0000_0044, 4'b0011, 32'hDEAD_BEEF, stall, rd, unst);
      checks++;
      if ({stall, wr_count - wr0, wr_addr_last, wr_strb_last} !== {32'd2, 32'd1, 30'h11, 4'b0011}) begin
         failures++;
         $display("FAIL store_hit: got stall=%0d writes=%0d addr=%h strb=%b required 2 1 11 0011",
                  stall, wr_count - wr0, wr_addr_last, wr_strb_last);
      end
      run_req(32'h0000_0048, 4'b1000, 32'h9900_0000, stall, rd, unst);
      checks++;
      if ({stall, wr_count - wr0} !== {32'd2, 32'd2}) begin
         failures++;
         $display("FAIL b2b_store: got stall=%0d writes=%0d required 2 2", stall, wr_count - wr0);
      end
      checks++;
      if ({mem_req_o, cpu_blocking_n_o} !== 2'b01) begin
         failures++;
         $display("FAIL done_no_reissue: got req/blk=%b required 01", {mem_req_o, cpu_blocking_n_o});
      end
      run_req(32'h0000_0044, 4'h0, 32'h0, stall, rd, unst);
      checks++;
      if ({stall, rd} !== {32'd0, 32'h0000_BEEF}) begin
         failures++;
         $display("FAIL merge_low: got stall=%0d data=%h required 0 0000beef", stall, rd);
      end
      run_req(32'h0000_0048, 4'h0, 32'h0, stall, rd, unst);
      checks++;
      if ({stall, rd, wr_count - wr0, rd_count - rd0} !== {32'd0, 32'h9900_0033, 32'd2, 32'd0}) begin
         failures++;
         $display("FAIL merge_high: got stall=%0d data=%h writes=%0d reads=%0d required 0 99000033 2 0",
                  stall, rd, wr_count - wr0, rd_count - rd0);
      end
   endtask

   task automatic test_store_miss;
      int          stall, unst;
      logic [31:0] rd;
      int unsigned wr0, rd0;
      wr0 = wr_count;
      rd0 = rd_count;
      run_req(32'h0000_0800, 4'hF, 32'h1234_5678, stall, rd, unst);
      checks++;
      if ({stall, wr_count - wr0, rd_count - rd0} !== {32'd2, 32'd1, 32'd0}) begin
         failures++;
         $display("FAIL store_miss: got stall=%0d writes=%0d reads=%0d required 2 1 0",
                  stall, wr_count - wr0, rd_count - rd0);
      end
      run_req(32'h0000_0800, 4'h0, 32'h0, stall, rd, unst);
      checks++;
      if ({stall, rd, rd_count - rd0} !== {32'd5, 32'h1234_5678, 32'd4}) begin
         failures++;
         $display("FAIL no_allocate: got stall=%0d data=%h reads=%0d required 5 12345678 4",
                  stall, rd, rd_count - rd0);
      end
   endtask

   task automatic test_reset_mid_refill;
      int          stall, unst;
      logic [31:0] rd;
      int unsigned rd0;
      rd0 = rd_count;
      cpu_enabled_i  = 1'b1;
      cpu_address_i  = 30'h0000_0040;
      cpu_write_en_i = 4'h0;
      #1;
      cyc();
      cyc();
      cyc();
      checks++;
      if ({rd_count - rd0, mem_req_o} !== {32'd2, 1'b1}) begin
         failures++;
         $display("FAIL mid_refill: got reads=%0d req=%b required 2 1", rd_count - rd0, mem_req_o);
      end
      rst_i = 1'b0;
      #1;
      checks++;
      if ({mem_req_o, cpu_blocking_n_o, cpu_data_o} !== {2'b01, 32'h0}) begin
         failures++;
         $display("FAIL reset_during_refill: got req=%b blk=%b data=%h required 0 1 0",
                  mem_req_o, cpu_blocking_n_o, cpu_data_o);
      end
      cyc();
      rst_i         = 1'b1;
      cpu_enabled_i = 1'b0;
      #1;
      checks++;
      if ({mem_req_o, cpu_blocking_n_o} !== 2'b01) begin
         failures++;
         $display("FAIL after_reset: got req/blk=%b required 01", {mem_req_o, cpu_blocking_n_o});
      end
      run_req(32'h0000_0100, 4'h0, 32'h0, stall, rd, unst);
      checks++;
      if ({stall, rd, rd_count - rd0} !== {32'd5, 32'h5000_0040, 32'd6}) begin
         failures++;
         $display("FAIL refill_again: got stall=%0d data=%h reads=%0d required 5 50000040 6",
                  stall, rd, rd_count - rd0);
      end
      run_req(32'h0000_0040, 4'h0, 32'h0, stall, rd, unst);
      checks++;
      if ({stall, rd} !== {32'd5, 32'h0000_0011}) begin
         failures++;
         $display("FAIL valid_cleared: got stall=%0d data=%h required 5 00000011", stall, rd);
      end
   endtask

   task automatic test_delayed_ack;
      int          stall, unst;
      logic [31:0] rd;
      int unsigned wr0;
      ack_delay = 3;
      run_req(32'h0000_0200, 4'h0, 32'h0, stall, rd, unst);
      checks++;
      if ({stall, rd, unst} !== {32'd17, 32'h5000_0080, 32'd0}) begin
         failures++;
         $display("FAIL slow_load: got stall=%0d data=%h unstable=%0d required 17 50000080 0",
                  stall, rd, unst);
      end
      for (int i = 0; i < 2; i++) begin
         cyc();
         checks++;
         if ({cpu_blocking_n_o, mem_req_o} !== 2'b10) begin
            failures++;
            $display("FAIL idle_gap: got blk/req=%b required 10", {cpu_blocking_n_o, mem_req_o});
         end
      end
      wr0 = wr_count;
      run_req(32'h0000_0200, 4'b1100, 32'hAABB_CCDD, stall, rd, unst);
      checks++;
      if ({stall, unst, wr_count - wr0, wr_strb_last} !== {32'd5, 32'd0, 32'd1, 4'b1100}) begin
         failures++;
         $display("FAIL slow_store: got stall=%0d unstable=%0d writes=%0d strb=%b required 5 0 1 1100",
                  stall, unst, wr_count - wr0, wr_strb_last);
      end
      cyc();
      run_req(32'h0000_0200, 4'h0, 32'h0, stall, rd, unst);
      checks++;
      if ({stall, rd} !== {32'd0, 32'hAABB_0080}) begin
         failures++;
         $display("FAIL slow_merge: got stall=%0d data=%h required 0 aabb0080", stall, rd);
      end
`ifdef DCACHE_PERF_CNT_EN
      checks++;
      if ({hit_count_o, miss_count_o} !== {32'd2, 32'd3}) begin
         failures++;
         $display("FAIL perf_counters: got hit=%0d miss=%0d required 2 3", hit_count_o, miss_count_o);
      end
`endif
   endtask

   initial begin
      rst_i          = 1'b0;
      cpu_enabled_i  = 1'b0;
      cpu_address_i  = '0;
      cpu_write_en_i = '0;
      cpu_data_i     = '0;
      ack_delay      = 0;
      test_reset();
      test_cold_load();
      test_conflict();
      test_back_to_back_store_hit();
      test_store_miss();
      test_reset_mid_refill();
      test_delayed_ack();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
